// File: rtl/button_conditioner_pkg.sv
// Shared types and 27 MHz timing defaults for the push-button conditioner.
// Pure declarations: no latency, no backpressure.
package btn_pkg;

   typedef enum logic [1:0] {
      ST_RELEASED    = 2'd0,
      ST_PRESS_CHK   = 2'd1,
      ST_HELD        = 2'd2,
      ST_RELEASE_CHK = 2'd3
   } btn_state_t;

   localparam int CLK_HZ              = 27_000_000;
   localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;  // 10 ms
   localparam int DEF_LONG_CYCLES     = CLK_HZ;        // 1 s
   localparam int DEF_REPEAT_CYCLES   = CLK_HZ / 5;    // 200 ms

endpackage

// File: rtl/button_conditioner_if.sv
// Raw button pins in, conditioned level and strobes out.
// Wires only: no latency, no backpressure.
interface button_conditioner_if #(
   parameter int N_BTN = 2
);
   logic [N_BTN-1:0] btn_raw_n;
   logic [N_BTN-1:0] btn_level_n;
   logic [N_BTN-1:0] press_pulse;
   logic [N_BTN-1:0] release_pulse;
   logic [N_BTN-1:0] long_pulse;
   logic [N_BTN-1:0] repeat_pulse;

   modport master (
      output btn_raw_n,
      input  btn_level_n, press_pulse, release_pulse, long_pulse, repeat_pulse
   );

   modport slave (
      input  btn_raw_n,
      output btn_level_n, press_pulse, release_pulse, long_pulse, repeat_pulse
   );
endinterface

// File: rtl/button_conditioner_debounce_core.sv
// One button: 2-flop sync, debounce, press/release FSM, long/repeat hold timer.
// Level and strobes registered, DEBOUNCE_CYCLES+2 edges after a raw change; no backpressure.
module debounce_core
   import btn_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
   input  logic                 clk,
   input  logic                 rst_n,
   button_conditioner_if.slave  bus
);

   localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_MAX = LONG_CYCLES + REPEAT_CYCLES - 1;
   localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX);
   localparam logic [HOLD_W-1:0] HOLD_WRAP = HOLD_W'(LONG_CYCLES);

   btn_state_t        state_q, state_d;
   logic              s1_q, s1_d, s2_q, s2_d;
   logic              stable_q, stable_d;
   logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              press_q, press_d, release_q, release_d;
   logic              long_q, long_d, repeat_q, repeat_d;
   logic              differ, accept, counting;

   assign differ = (s2_q != stable_q);
   assign accept = differ && (db_cnt_q == DB_LAST);

   always_comb begin
      s1_d       = bus.btn_raw_n[0];
      s2_d       = s1_q;
      stable_d   = accept ? ~stable_q : stable_q;
      db_cnt_d   = (!differ || accept) ? '0 : db_cnt_q + 1'b1;
      state_d    = state_q;
      hold_cnt_d = hold_cnt_q;
      press_d    = 1'b0;
      release_d  = 1'b0;
      long_d     = 1'b0;
      repeat_d   = 1'b0;
      counting   = 1'b0;

      case (state_q)
         ST_RELEASED: begin
            hold_cnt_d = '0;
            if (!s2_q) state_d = ST_PRESS_CHK;
         end
         ST_PRESS_CHK: begin
            if (s2_q) begin
               state_d = ST_RELEASED;
            end else if (accept) begin
               state_d    = ST_HELD;
               press_d    = 1'b1;
               hold_cnt_d = '0;
            end
         end
         ST_HELD: begin
            counting = 1'b1;
            if (s2_q) state_d = ST_RELEASE_CHK;
         end
         ST_RELEASE_CHK: begin
            if (!s2_q) begin
               state_d  = ST_HELD;
               counting = 1'b1;
            end else if (accept) begin
               // the release edge itself carries no long/repeat strobe
               state_d    = ST_RELEASED;
               release_d  = 1'b1;
               hold_cnt_d = '0;
            end else begin
               counting = 1'b1;
            end
         end
         default: state_d = ST_RELEASED;
      endcase

      // once past LONG the counter loops over one repeat period instead of growing
      if (counting) begin
         hold_cnt_d = (hold_cnt_q == HOLD_LAST) ? HOLD_WRAP : hold_cnt_q + 1'b1;
         long_d     = (hold_cnt_q == LONG_LAST);
         repeat_d   = (hold_cnt_q == LONG_LAST) || (hold_cnt_q == HOLD_LAST);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_RELEASED;
         s1_q       <= 1'b1;
         s2_q       <= 1'b1;
         stable_q   <= 1'b1;
         db_cnt_q   <= '0;
         hold_cnt_q <= '0;
         press_q    <= 1'b0;
         release_q  <= 1'b0;
         long_q     <= 1'b0;
         repeat_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         stable_q   <= stable_d;
         db_cnt_q   <= db_cnt_d;
         hold_cnt_q <= hold_cnt_d;
         press_q    <= press_d;
         release_q  <= release_d;
         long_q     <= long_d;
         repeat_q   <= repeat_d;
      end
   end

   assign bus.btn_level_n[0]   = stable_q;
   assign bus.press_pulse[0]   = press_q;
   assign bus.release_pulse[0] = release_q;
   assign bus.long_pulse[0]    = long_q;
   assign bus.repeat_pulse[0]  = repeat_q;

endmodule

// File: rtl/button_conditioner.sv
// N_BTN independent button conditioners; clean active-low level plus press/release/long/repeat strobes.
// Outputs registered, DEBOUNCE_CYCLES+2 edges after a stable raw change; no backpressure.
module button_conditioner
   import btn_pkg::*;
#(
   parameter int N_BTN           = 2,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int LONG_CYCLES     = DEF_LONG_CYCLES,
   parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_raw_n,
   output logic [N_BTN-1:0] btn_level_n,
   output logic [N_BTN-1:0] press_pulse,
   output logic [N_BTN-1:0] release_pulse,
   output logic [N_BTN-1:0] long_pulse,
   output logic [N_BTN-1:0] repeat_pulse
);

   if (N_BTN < 1) begin : g_bad_n
      $fatal(1, "N_BTN must be >= 1");
   end
   if (DEBOUNCE_CYCLES < 2) begin : g_bad_db
      $fatal(1, "DEBOUNCE_CYCLES must be >= 2");
   end
   if (LONG_CYCLES < 1) begin : g_bad_long
      $fatal(1, "LONG_CYCLES must be >= 1");
   end
   if (REPEAT_CYCLES < 1) begin : g_bad_rep
      $fatal(1, "REPEAT_CYCLES must be >= 1");
   end

   for (genvar i = 0; i < N_BTN; i++) begin : g_btn
      button_conditioner_if #(.N_BTN(1)) u_if ();

      assign u_if.btn_raw_n[0] = btn_raw_n[i];
      assign btn_level_n[i]    = u_if.btn_level_n[0];
      assign press_pulse[i]    = u_if.press_pulse[0];
      assign release_pulse[i]  = u_if.release_pulse[0];
      assign long_pulse[i]     = u_if.long_pulse[0];
      assign repeat_pulse[i]   = u_if.repeat_pulse[0];

      debounce_core #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .LONG_CYCLES     (LONG_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES)
      ) u_core (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (u_if.slave)
      );
   end

endmodule
